// File: rtl/matrix_scan_bcm_if.sv
// Scan-controller bus: pause control in, framebuffer addressing and panel strobes out.
// All controller-driven signals are registered; enable is only sampled at plane boundaries.
interface matrix_scan_bcm_if #(
   parameter int COLUMNS         = 64,
   parameter int ROW_ADDR_WIDTH  = 4,
   parameter int BRIGHTNESS_BITS = 6
);
   localparam int COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

   logic                       enable;
   logic [COL_W-1:0]           column_address;
   logic [ROW_ADDR_WIDTH-1:0]  row_address;
   logic [ROW_ADDR_WIDTH-1:0]  row_address_active;
   logic [BRIGHTNESS_BITS-1:0] brightness_mask;
   logic                       pixel_req;
   logic                       clk_pixel;
   logic                       row_latch;
   logic                       output_enable;
   logic                       frame_start;

   modport master (
      input  enable,
      output column_address, row_address, row_address_active, brightness_mask,
             pixel_req, clk_pixel, row_latch, output_enable, frame_start
   );

   modport slave (
      output enable,
      input  column_address, row_address, row_address_active, brightness_mask,
             pixel_req, clk_pixel, row_latch, output_enable, frame_start
   );
endinterface

// File: rtl/matrix_scan_bcm.sv
// HUB75 scan controller with BCM output enable; plane period max(2*COLUMNS, OE+BLANK)+1 cycles.
// Outputs registered; enable sampled only in IDLE and at LATCH, so a pause never truncates shift or OE.
module matrix_scan_bcm #(
   parameter int COLUMNS         = 64,
   parameter int ROW_ADDR_WIDTH  = 4,
   parameter int BRIGHTNESS_BITS = 6,
   parameter int OE_BASE         = 2,
   parameter int BLANK_CYCLES    = 8
) (
   input logic               clk_in,
   input logic               reset,
   matrix_scan_bcm_if.master bus
);
   localparam int     COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
   localparam int     PLN_W  = (BRIGHTNESS_BITS > 1) ? $clog2(BRIGHTNESS_BITS) : 1;
   localparam longint OE_MAX = longint'(OE_BASE) << (BRIGHTNESS_BITS - 1);
   localparam int     OE_W   = $clog2(OE_MAX) + 1;
   localparam int     BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   localparam logic [COL_W-1:0]           COL_LAST = COL_W'(COLUMNS - 1);
   localparam logic [PLN_W-1:0]           PLN_MSB  = PLN_W'(BRIGHTNESS_BITS - 1);
   localparam logic [BRIGHTNESS_BITS-1:0] MASK_MSB = BRIGHTNESS_BITS'(1) << (BRIGHTNESS_BITS - 1);
   // Blank counter holds low cycles seen before the current one; ready when the current cycle completes the gap.
   localparam logic [BLK_W-1:0]           BLK_NEED = BLK_W'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_LATCH} state_t;

   state_t                     state, state_nxt;
   logic                       phase, phase_nxt;
   logic [COL_W-1:0]           col;
   logic [ROW_ADDR_WIDTH-1:0]  row, row_act;
   logic [PLN_W-1:0]           plane, plane_act;
   logic [BRIGHTNESS_BITS-1:0] mask;
   logic [OE_W-1:0]            oe_cnt, oe_len;
   logic [BLK_W-1:0]           blank_cnt;
   logic                       oe, req, pclk, latch, fstart;
   logic                       req_nxt, pclk_nxt, latch_nxt, fstart_nxt;
   logic                       col_step, enter_latch, load_oe, ready;

   assign ready  = !oe && (blank_cnt == BLK_NEED);
   assign oe_len = OE_W'(OE_BASE) << plane_act;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         phase <= 1'b0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase;
      req_nxt     = 1'b0;
      pclk_nxt    = 1'b0;
      latch_nxt   = 1'b0;
      fstart_nxt  = 1'b0;
      col_step    = 1'b0;
      enter_latch = 1'b0;
      load_oe     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.enable) begin
               state_nxt = S_SHIFT;
               phase_nxt = 1'b0;
               req_nxt   = 1'b1;
            end
         end
         S_SHIFT: begin
            if (!phase) begin
               phase_nxt = 1'b1;
               pclk_nxt  = 1'b1;
            end else begin
               phase_nxt = 1'b0;
               col_step  = 1'b1;
               if (col != '0) begin
                  req_nxt = 1'b1;
               end else if (ready) begin
                  state_nxt   = S_LATCH;
                  enter_latch = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (ready) begin
               state_nxt   = S_LATCH;
               enter_latch = 1'b1;
            end
         end
         S_LATCH: begin
            load_oe = 1'b1;
            if (bus.enable) begin
               state_nxt = S_SHIFT;
               phase_nxt = 1'b0;
               req_nxt   = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (enter_latch) begin
         latch_nxt  = 1'b1;
         fstart_nxt = (row == '0) && (plane == PLN_MSB);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         col       <= COL_LAST;
         row       <= '0;
         row_act   <= '0;
         plane     <= PLN_MSB;
         plane_act <= PLN_MSB;
         mask      <= MASK_MSB;
         req       <= 1'b0;
         pclk      <= 1'b0;
         latch     <= 1'b0;
         fstart    <= 1'b0;
         oe        <= 1'b0;
         oe_cnt    <= '0;
         blank_cnt <= BLK_NEED;
      end else begin
         req    <= req_nxt;
         pclk   <= pclk_nxt;
         latch  <= latch_nxt;
         fstart <= fstart_nxt;
         if (col_step) col <= (col == '0) ? COL_LAST : col - COL_W'(1);
         // Active row/plane move with the latch edge; the OE length is taken from them one cycle later.
         if (enter_latch) begin
            row_act   <= row;
            plane_act <= plane;
            if (plane == '0) begin
               plane <= PLN_MSB;
               mask  <= MASK_MSB;
               row   <= row + ROW_ADDR_WIDTH'(1);
            end else begin
               plane <= plane - PLN_W'(1);
               mask  <= mask >> 1;
            end
         end
         if (load_oe) begin
            oe_cnt <= oe_len;
            oe     <= 1'b1;
         end else if (oe_cnt != '0) begin
            oe_cnt <= oe_cnt - OE_W'(1);
            oe     <= (oe_cnt != OE_W'(1));
         end
         if (oe)                          blank_cnt <= '0;
         else if (blank_cnt != BLK_NEED)  blank_cnt <= blank_cnt + BLK_W'(1);
      end
   end

   assign bus.column_address     = col;
   assign bus.row_address        = row;
   assign bus.row_address_active = row_act;
   assign bus.brightness_mask    = mask;
   assign bus.pixel_req          = req;
   assign bus.clk_pixel          = pclk;
   assign bus.row_latch          = latch;
   assign bus.output_enable      = oe;
   assign bus.frame_start        = fstart;
endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Bench for matrix_scan_bcm: three configurations checked every cycle against a schedule model,
// plus a cycle table for the small panel and directed pause/asynchronous-reset sequences.
module tb_matrix_scan_bcm;
   logic clk;
   logic reset;
   logic enable;
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int inst, input int cyc, input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL dut%0d cycle %0d %s: got %0d, expected %0d", inst, cyc, name, act, exp);
      end
   endtask

   // Instance 0: small panel, 1: long OE forcing WAIT, 2: default parameters.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int C    = (g == 2) ? 64 : 4;
      localparam int RW   = (g == 2) ? 4 : 2;
      localparam int BB   = (g == 2) ? 6 : 3;
      localparam int OB   = (g == 1) ? 4 : 2;
      localparam int BL   = (g == 2) ? 8 : 3;
      localparam int ROWS = 1 << RW;

      matrix_scan_bcm_if #(.COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BRIGHTNESS_BITS(BB)) bus ();
      assign bus.enable = enable;

      matrix_scan_bcm #(
         .COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BRIGHTNESS_BITS(BB), .OE_BASE(OB), .BLANK_CYCLES(BL)
      ) u_dut (
         .clk_in (clk),
         .reset  (reset),
         .bus    (bus)
      );

      // Schedule model: shift window start, predicted latch cycle, and the last OE pulse.
      int t, n, p_start, lx, l_prev, oe_end;
      bit shifting;

      always @(negedge clk) begin
         bit in_shift, e_latch, e_fs, decide;
         int rel;
         if (!reset) begin
            t = 0; n = 0; shifting = 0; p_start = 0; lx = 0;
            l_prev = -100000; oe_end = -100000;
            chk(g, t, "rst_column_address", int'(bus.column_address), C - 1);
            chk(g, t, "rst_row_address", int'(bus.row_address), 0);
            chk(g, t, "rst_row_active", int'(bus.row_address_active), 0);
            chk(g, t, "rst_mask", int'(bus.brightness_mask), 1 << (BB - 1));
            chk(g, t, "rst_strobes", int'({bus.pixel_req, bus.clk_pixel, bus.row_latch, bus.frame_start}), 0);
            chk(g, t, "rst_output_enable", int'(bus.output_enable), 0);
         end else begin
            t = t + 1;
            rel      = t - p_start;
            in_shift = shifting && (rel >= 0) && (rel < 2 * C);
            e_latch  = shifting && (t == lx);
            decide   = e_latch || !shifting;
            e_fs     = 0;
            if (e_latch) begin
               e_fs   = (((n / BB) % ROWS) == 0) && ((n % BB) == 0);
               l_prev = t;
               oe_end = t + (OB << (BB - 1 - (n % BB)));
               n      = n + 1;
            end
            chk(g, t, "pixel_req", int'(bus.pixel_req), int'(in_shift && (rel % 2 == 0)));
            chk(g, t, "clk_pixel", int'(bus.clk_pixel), int'(in_shift && (rel % 2 == 1)));
            chk(g, t, "column_address", int'(bus.column_address), in_shift ? (C - 1 - rel / 2) : (C - 1));
            chk(g, t, "row_latch", int'(bus.row_latch), int'(e_latch));
            chk(g, t, "frame_start", int'(bus.frame_start), int'(e_fs));
            chk(g, t, "output_enable", int'(bus.output_enable), int'((t > l_prev) && (t <= oe_end)));
            chk(g, t, "row_address", int'(bus.row_address), (n / BB) % ROWS);
            chk(g, t, "row_active", int'(bus.row_address_active), (n == 0) ? 0 : ((n - 1) / BB) % ROWS);
            chk(g, t, "brightness_mask", int'(bus.brightness_mask), 1 << (BB - 1 - (n % BB)));
            if (decide) begin
               shifting = 0;
               if (enable) begin
                  shifting = 1;
                  p_start  = t + 1;
                  lx = (p_start + 2 * C > oe_end + BL + 1) ? (p_start + 2 * C) : (oe_end + BL + 1);
               end
            end
         end
      end
   end

   typedef struct {
      bit en;
      bit req;
      bit pclk;
      int col;
      bit latch;
      bit fs;
      bit oe;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   initial begin
      bit found;
      //            en req clk col lat fs oe
      tbl[0]  = '{1, 0, 0, 3, 0, 0, 0};
      tbl[1]  = '{1, 1, 0, 3, 0, 0, 0};
      tbl[2]  = '{1, 0, 1, 3, 0, 0, 0};
      tbl[3]  = '{1, 1, 0, 2, 0, 0, 0};
      tbl[4]  = '{1, 0, 1, 2, 0, 0, 0};
      tbl[5]  = '{1, 1, 0, 1, 0, 0, 0};
      tbl[6]  = '{1, 0, 1, 1, 0, 0, 0};
      tbl[7]  = '{1, 1, 0, 0, 0, 0, 0};
      tbl[8]  = '{1, 0, 1, 0, 0, 0, 0};
      tbl[9]  = '{1, 0, 0, 3, 1, 1, 0};
      tbl[10] = '{1, 1, 0, 3, 0, 0, 1};
      tbl[11] = '{1, 0, 1, 3, 0, 0, 1};
      tbl[12] = '{1, 1, 0, 2, 0, 0, 1};
      tbl[13] = '{1, 0, 1, 2, 0, 0, 1};
      tbl[14] = '{1, 1, 0, 1, 0, 0, 1};
      tbl[15] = '{1, 0, 1, 1, 0, 0, 1};
      tbl[16] = '{1, 1, 0, 0, 0, 0, 1};
      tbl[17] = '{1, 0, 1, 0, 0, 0, 1};
      tbl[18] = '{1, 0, 0, 3, 0, 0, 0};
      tbl[19] = '{1, 0, 0, 3, 0, 0, 0};
      tbl[20] = '{1, 0, 0, 3, 0, 0, 0};
      tbl[21] = '{0, 0, 0, 3, 1, 0, 0};
      tbl[22] = '{0, 0, 0, 3, 0, 0, 1};
      tbl[23] = '{0, 0, 0, 3, 0, 0, 1};
      tbl[24] = '{1, 0, 0, 3, 0, 0, 1};
      tbl[25] = '{1, 1, 0, 3, 0, 0, 1};
      tbl[26] = '{1, 0, 1, 3, 0, 0, 0};
      tbl[27] = '{1, 1, 0, 2, 0, 0, 0};

      reset  = 1'b1;
      enable = 1'b0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         enable = tbl[i].en;
         @(negedge clk);
         chk(0, i, "tbl_pixel_req", int'(g_dut[0].bus.pixel_req), int'(tbl[i].req));
         chk(0, i, "tbl_clk_pixel", int'(g_dut[0].bus.clk_pixel), int'(tbl[i].pclk));
         chk(0, i, "tbl_column_address", int'(g_dut[0].bus.column_address), tbl[i].col);
         chk(0, i, "tbl_row_latch", int'(g_dut[0].bus.row_latch), int'(tbl[i].latch));
         chk(0, i, "tbl_frame_start", int'(g_dut[0].bus.frame_start), int'(tbl[i].fs));
         chk(0, i, "tbl_output_enable", int'(g_dut[0].bus.output_enable), int'(tbl[i].oe));
         @(posedge clk);
         #1;
      end

      // Mostly running, with occasional pauses of random length.
      for (int i = 0; i < 4000; i++) begin
         if (enable) begin
            if ($urandom_range(0, 199) == 0) enable = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            enable = 1'b1;
         end
         @(posedge clk);
         #1;
      end

      // Asynchronous reset while LEDs are lit during a shift.
      enable = 1'b1;
      found  = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         found = g_dut[0].bus.output_enable && (g_dut[0].bus.pixel_req || g_dut[0].bus.clk_pixel);
      end
      chk(0, -1, "find_oe_during_shift", int'(found), 1);
      #1 reset = 1'b0;
      #1;
      chk(0, -1, "async_column_address", int'(g_dut[0].bus.column_address), 3);
      chk(0, -1, "async_row_address", int'(g_dut[0].bus.row_address), 0);
      chk(0, -1, "async_row_active", int'(g_dut[0].bus.row_address_active), 0);
      chk(0, -1, "async_mask", int'(g_dut[0].bus.brightness_mask), 4);
      chk(0, -1, "async_pixel_req", int'(g_dut[0].bus.pixel_req), 0);
      chk(0, -1, "async_clk_pixel", int'(g_dut[0].bus.clk_pixel), 0);
      chk(0, -1, "async_output_enable", int'(g_dut[0].bus.output_enable), 0);
      chk(2, -1, "async_output_enable", int'(g_dut[2].bus.output_enable), 0);
      chk(2, -1, "async_column_address", int'(g_dut[2].bus.column_address), 63);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         found = g_dut[0].bus.row_latch;
      end
      chk(0, -1, "restart_latch_seen", int'(found), 1);
      chk(0, -1, "restart_frame_start", int'(g_dut[0].bus.frame_start), 1);
      chk(0, -1, "restart_row_active", int'(g_dut[0].bus.row_address_active), 0);
      chk(0, -1, "restart_next_mask", int'(g_dut[0].bus.brightness_mask), 2);

      repeat (400) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/matrix_scan_bcm.md
# matrix_scan_bcm

Fully synchronous, parametrised HUB75-style LED matrix scan controller: generates the column address, pixel request/clock, row latch, row address and binary-code-modulated output enable for any panel width, row count and colour depth. Replaces gated-clock scanning with clock enables and registered outputs. It adds a programmable blanking gap, a run/pause control and a frame-start strobe. Sits between the framebuffer read logic (driven by `column_address`, `row_address`, `brightness_mask`, `pixel_req`) and the panel pins.

## Interface
- `COLUMNS`, 64: pixels shifted per row-plane (≥2).
- `ROW_ADDR_WIDTH`, 4: row address bits; rows = 2^ROW_ADDR_WIDTH.
- `BRIGHTNESS_BITS`, 6: bit planes per row (1..8).
- `OE_BASE`, 2: output-enable cycles for the LSB plane; plane p lasts OE_BASE<<p.
- `BLANK_CYCLES`, 8: minimum cycles output_enable must be low before row_latch (≥1).

- `clk_in` input 1: sole clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `enable` input 1: run when 1; pause at the next plane boundary when 0.
- `column_address` output clog2(COLUMNS): column being requested, counts COLUMNS-1 down to 0.
- `row_address` output ROW_ADDR_WIDTH: row being shifted.
- `row_address_active` output ROW_ADDR_WIDTH: row driven to panel (lit).
- `brightness_mask` output BRIGHTNESS_BITS: one-hot plane being shifted.
- `pixel_req` output 1: one-cycle request; data for `column_address` must be registered by the consumer on this edge.
- `clk_pixel` output 1: registered panel shift clock.
- `row_latch` output 1: one-cycle panel latch strobe.
- `output_enable` output 1: LEDs on (active-high; pin inversion external).
- `frame_start` output 1: one-cycle strobe at the latch of row 0, MSB plane.

## Operation
- States: IDLE, SHIFT, WAIT, LATCH.
- IDLE: all strobes 0. Go to SHIFT when `enable`=1.
- SHIFT: 2 cycles per column. Phase A: `pixel_req`=1, `clk_pixel`=0. Phase B: `pixel_req`=0, `clk_pixel`=1. `column_address` decrements after phase B and wraps to COLUMNS-1 after column 0. After column 0 phase B, go to LATCH if ready, else WAIT.
- Ready = `output_enable`=0 AND low for ≥BLANK_CYCLES consecutive cycles. Blank counter saturates and resets to saturated, so the first latch is never blocked.
- WAIT: hold with all strobes 0 until ready, then LATCH.
- LATCH: `row_latch`=1 for one cycle. On this edge:
  - `row_address_active`←`row_address`; active plane←current plane.
  - Plane advances MSB→LSB. After LSB, plane←MSB and `row_address`+1, wrapping 2^ROW_ADDR_WIDTH-1→0.
  - `frame_start`=1 in this cycle iff the latched row is 0 and the latched plane is the MSB.
- Next state after LATCH: SHIFT if `enable`=1, else IDLE.
- OE timer loads on the cycle after LATCH: `output_enable`=1 for exactly OE_BASE<<p cycles, where p is the index of the latched plane. It runs concurrently with the next SHIFT and continues in IDLE.
- Timer width is clog2(OE_BASE<<(BRIGHTNESS_BITS-1))+1. Compute without truncation.
- `enable` is sampled only in IDLE and at LATCH. A pause never truncates shift or OE.

## Timing
- Reset values: `column_address`=COLUMNS-1, `row_address`=0, `row_address_active`=0, `brightness_mask`=MSB one-hot, every strobe and `output_enable`=0, state IDLE. Reset asserted mid-operation forces these immediately (asynchronously).
- First edge with `reset`=1 and `enable`=1: IDLE→SHIFT. The first `pixel_req` is in the following cycle.
- Shift of one plane: 2·COLUMNS cycles. Latch follows with 0 WAIT cycles when ready.
- Plane period = max(2·COLUMNS, OE_len+BLANK_CYCLES) + 1 cycles.
- `row_latch` and `output_enable` are never both 1. `row_address_active` changes only on a LATCH edge.
- All outputs are registered; no combinational path from `enable` to outputs.

## Test plan
- Reset, COLUMNS=4, ROW_ADDR_WIDTH=2, BRIGHTNESS_BITS=3, OE_BASE=2, BLANK_CYCLES=3, enable=1 → 4 `pixel_req` with column_address 3,2,1,0; 4 `clk_pixel` pulses interleaved; `row_latch` the cycle after the 4th; `frame_start`=1 with it; `output_enable` high 8 cycles.
- Same config, run 12 latches → `brightness_mask` 100,010,001 repeating; OE widths 8,4,2; `row_address_active` 0,0,0,1,1,1…; row wraps 3→0 with `frame_start` on the 13th latch.
- COLUMNS=4, OE_BASE=4, BLANK_CYCLES=3 → MSB plane (16-cycle OE) forces WAIT; gap from `output_enable` fall to `row_latch` exactly 3 cycles.
- Drop `enable` mid-SHIFT → current shift, latch and full OE complete; then IDLE with no further `pixel_req`. Re-raising `enable` resumes at the next plane/row with no skip.
- Assert `reset`=0 while `output_enable`=1 mid-shift → all outputs at reset values before the next clock edge. After release, sequence restarts at row 0, MSB plane.
- Default parameters → 128 shift cycles per plane; the LSB plane is shift-limited (plane period 129 cycles); OE widths 64..2 observed.
